// File: rtl/timer.sv
// ---------------------------------------------------------------------------
// timer -- loadable down-counter timer driven by an external tick qualifier.
//
// A start loads Value and begins counting down one step per clk edge on
// which oneHz_enable is high. After exactly Value ticks, expired rises and
// stays high as a level until the next start or reset. A start with Value=0
// expires immediately.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   Reset_Sync   in   synchronous active-high reset (highest priority)
//   Value        in   WIDTH-bit duration in ticks, sampled only on a start
//   oneHz_enable in   one-clk-wide tick qualifier
//   start_timer  in   load Value and begin counting (beats a same-edge tick)
//   expired      out  registered, high once the duration has elapsed
//   busy         out  registered, high while counting
//   remaining    out  registered, current counter value
// ---------------------------------------------------------------------------
module timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             Reset_Sync,
    input  logic [WIDTH-1:0] Value,
    input  logic             oneHz_enable,
    input  logic             start_timer,
    output logic             expired,
    output logic             busy,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (Reset_Sync) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else if (start_timer) begin
            // A start always wins; any same-edge tick is discarded.
            if (Value != '0) begin
                state     <= RUN;
                remaining <= Value;
                busy      <= 1'b1;
                expired   <= 1'b0;
            end else begin
                state     <= IDLE;
                remaining <= '0;
                busy      <= 1'b0;
                expired   <= 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (oneHz_enable) begin
                        if (remaining == WIDTH'(1)) begin
                            state     <= IDLE;
                            remaining <= '0;
                            busy      <= 1'b0;
                            expired   <= 1'b1;
                        end else begin
                            remaining <= remaining - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    // IDLE: ticks ignored, counter never wraps below zero.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer.sv
// ---------------------------------------------------------------------------
// tb_timer -- self-checking bench for timer (WIDTH=4).
// A table of {inputs, expected outputs} records is applied one per clk edge,
// followed by hand-written sequences for tick gaps and restart.
// ---------------------------------------------------------------------------
module tb_timer;

    localparam int unsigned W = 4;

    logic         clk;
    logic         Reset_Sync;
    logic [W-1:0] Value;
    logic         oneHz_enable;
    logic         start_timer;
    logic         expired;
    logic         busy;
    logic [W-1:0] remaining;

    int total;
    int bad;

    timer #(.WIDTH(W)) dut (
        .clk          (clk),
        .Reset_Sync   (Reset_Sync),
        .Value        (Value),
        .oneHz_enable (oneHz_enable),
        .start_timer  (start_timer),
        .expired      (expired),
        .busy         (busy),
        .remaining    (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic         start;
        logic         tick;
        logic [W-1:0] val;
        logic         e;
        logic         b;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic start, input logic tick,
                                input logic [W-1:0] val, input logic e, input logic b,
                                input logic [W-1:0] r);
        vec_t v;
        v.rst = rst; v.start = start; v.tick = tick; v.val = val;
        v.e = e; v.b = b; v.r = r;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic e, input logic b, input logic [W-1:0] r);
        total++;
        if (expired !== e || busy !== b || remaining !== r) begin
            bad++;
            $display("FAIL %s: got expired=%b busy=%b remaining=%0d, want expired=%b busy=%b remaining=%0d",
                     nm, expired, busy, remaining, e, b, r);
        end
    endtask

    // Drive inputs while clk is low, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic start, input logic tick, input logic [W-1:0] val);
        @(negedge clk);
        Reset_Sync   = rst;
        start_timer  = start;
        oneHz_enable = tick;
        Value        = val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks;
        total = 0;
        bad   = 0;
        Reset_Sync = 1'b0; start_timer = 1'b0; oneHz_enable = 1'b0; Value = '0;

        //   rst start tick val   e  b  r
        add(1, 0, 0, 4'd0,  0, 0, 4'd0);     // reset state
        // basic count from 10
        add(0, 1, 0, 4'd10, 0, 1, 4'd10);
        for (int i = 1; i <= 9; i++)
            add(0, 0, 1, 4'd10, 0, 1, 4'(10 - i));
        add(0, 0, 1, 4'd10, 1, 0, 4'd0);     // 10th tick expires
        add(0, 0, 1, 4'd10, 1, 0, 4'd0);     // expired held, no wrap
        add(0, 0, 0, 4'd3,  1, 0, 4'd0);     // Value change ignored
        // zero load
        add(1, 0, 0, 4'd0,  0, 0, 4'd0);
        add(0, 1, 0, 4'd0,  1, 0, 4'd0);
        add(0, 0, 1, 4'd0,  1, 0, 4'd0);
        // priority: reset beats start
        add(1, 1, 1, 4'd5,  0, 0, 4'd0);
        // start and tick together: no decrement on load
        add(0, 1, 1, 4'd5,  0, 1, 4'd5);
        add(0, 0, 1, 4'd5,  0, 1, 4'd4);
        add(0, 0, 0, 4'd5,  0, 1, 4'd4);     // no tick: unchanged
        add(0, 0, 1, 4'd9,  0, 1, 4'd3);     // Value change mid-run ignored
        // reset mid-run
        add(0, 1, 0, 4'd6,  0, 1, 4'd6);
        add(0, 0, 1, 4'd6,  0, 1, 4'd5);
        add(0, 0, 1, 4'd6,  0, 1, 4'd4);
        add(1, 0, 1, 4'd6,  0, 0, 4'd0);
        add(0, 0, 1, 4'd6,  0, 0, 4'd0);
        add(0, 0, 1, 4'd6,  0, 0, 4'd0);
        add(0, 0, 1, 4'd6,  0, 0, 4'd0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].tick, vecs[i].val);
            check($sformatf("vec%0d", i), vecs[i].e, vecs[i].b, vecs[i].r);
        end

        // Tick gaps: Value=3, tick on every third clk; expires on the 9th clk.
        step(1, 0, 0, 4'd0);
        check("gap_reset", 0, 0, 4'd0);
        step(0, 1, 0, 4'd3);
        check("gap_load", 0, 1, 4'd3);
        ticks = 0;
        for (int c = 1; c <= 9; c++) begin
            step(0, 0, (c % 3) == 0, 4'd3);
            if ((c % 3) == 0) ticks++;
            if (ticks == 3)
                check($sformatf("gap_clk%0d", c), 1, 0, 4'd0);
            else
                check($sformatf("gap_clk%0d", c), 0, 1, 4'(3 - ticks));
        end

        // Restart: Value=8, three ticks, restart with Value=2.
        step(0, 1, 0, 4'd8);  check("rs_load8", 0, 1, 4'd8);
        step(0, 0, 1, 4'd8);  check("rs_t1",    0, 1, 4'd7);
        step(0, 0, 1, 4'd8);  check("rs_t2",    0, 1, 4'd6);
        step(0, 0, 1, 4'd8);  check("rs_t3",    0, 1, 4'd5);
        step(0, 1, 1, 4'd2);  check("rs_load2", 0, 1, 4'd2);
        step(0, 0, 1, 4'd2);  check("rs_t4",    0, 1, 4'd1);
        step(0, 0, 0, 4'd2);  check("rs_gap",   0, 1, 4'd1);
        step(0, 0, 1, 4'd2);  check("rs_exp",   1, 0, 4'd0);
        step(0, 0, 0, 4'd2);  check("rs_hold",  1, 0, 4'd0);
        // Start from expired IDLE clears expired.
        step(0, 1, 0, 4'd15); check("rs_max",   0, 1, 4'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
